// File: rtl/param_function_register_bank.sv
// Parametrised bank of NUM_REGS x WIDTH function registers with a shared op select and a wrap event flag.
// Optional build macro REG_SATURATE_EN: increment/decrement saturate instead of wrapping.
module param_function_register_bank #(
    parameter int               WIDTH     = 32,
    parameter int               NUM_REGS  = 4,
    parameter int               SEL_W     = $clog2(NUM_REGS),
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_REGS-1:0] enable,
    input  logic [2:0]          funSel,
    input  logic [WIDTH-1:0]    i,
    input  logic [SEL_W-1:0]    rd_sel_a,
    input  logic [SEL_W-1:0]    rd_sel_b,
    output logic [WIDTH-1:0]    o_a,
    output logic [WIDTH-1:0]    o_b,
    output logic                zero_a,
    output logic                wrap
);

    localparam int DEPTH = 1 << SEL_W;

    generate
        if (WIDTH < 16) begin : g_bad_width
            $error("param_function_register_bank: WIDTH must be >= 16");
        end
        if (NUM_REGS < 2) begin : g_bad_regs
            $error("param_function_register_bank: NUM_REGS must be >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] rd_tbl_s [DEPTH];

    // Returns {wrap_event, next_value} for one register.
    function automatic logic [WIDTH:0] apply_op(input logic [WIDTH-1:0] cur,
                                                input logic [2:0]       op,
                                                input logic [WIDTH-1:0] din);
        logic [WIDTH-1:0] nxt;
        logic             evt;
        nxt = cur;
        evt = 1'b0;
        case (op)
            3'b000: begin
                if (cur == '0) begin
                    evt = 1'b1;
`ifdef REG_SATURATE_EN
                    nxt = cur;
`else
                    nxt = cur - WIDTH'(1);
`endif
                end else begin
                    nxt = cur - WIDTH'(1);
                end
            end
            3'b001: begin
                if (cur == '1) begin
                    evt = 1'b1;
`ifdef REG_SATURATE_EN
                    nxt = cur;
`else
                    nxt = cur + WIDTH'(1);
`endif
                end else begin
                    nxt = cur + WIDTH'(1);
                end
            end
            3'b010:  nxt = din;
            3'b011:  nxt = '0;
            3'b100:  nxt = WIDTH'(din[7:0]);
            3'b101:  nxt = WIDTH'(din[15:0]);
            3'b110:  nxt = {cur[WIDTH-9:0], din[7:0]};
            3'b111:  nxt = WIDTH'($signed(din[15:0]));
            default: nxt = cur;
        endcase
        return {evt, nxt};
    endfunction

    // Next state for every register and the aggregated wrap event.
    always_comb begin
        logic [WIDTH:0] res;
        wrap_d = 1'b0;
        res    = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
            if (enable[k]) begin
                res       = apply_op(regs_q[k], funSel, i);
                regs_d[k] = res[WIDTH-1:0];
                wrap_d    = wrap_d | res[WIDTH];
            end else begin
                regs_d[k] = regs_q[k];
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
            wrap_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            wrap_q <= wrap_d;
        end
    end

    // Indices past NUM_REGS read as zero when NUM_REGS is not a power of two.
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_rd_tbl
            if (g < NUM_REGS) begin : g_live
                assign rd_tbl_s[g] = regs_q[g];
            end else begin : g_pad
                assign rd_tbl_s[g] = '0;
            end
        end
    endgenerate

    assign o_a    = rd_tbl_s[rd_sel_a];
    assign o_b    = rd_tbl_s[rd_sel_b];
    assign zero_a = (o_a == '0);
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_param_function_register_bank.sv
// Directed self-checking bench for param_function_register_bank (32x4 main instance, 16x3 for out-of-range reads).
module tb_param_function_register_bank;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  enable;
    logic [2:0]  funSel;
    logic [31:0] i;
    logic [1:0]  rd_sel_a, rd_sel_b;
    logic [31:0] o_a, o_b;
    logic        zero_a, wrap;

    logic [2:0]  enable3;
    logic [1:0]  rd_sel_a3, rd_sel_b3;
    logic [15:0] o_a3, o_b3;
    logic        zero_a3, wrap3;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    param_function_register_bank #(.WIDTH(32), .NUM_REGS(4)) u_dut (
        .clock(clock), .reset(reset), .enable(enable), .funSel(funSel), .i(i),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .o_a(o_a), .o_b(o_b), .zero_a(zero_a), .wrap(wrap)
    );

    param_function_register_bank #(.WIDTH(16), .NUM_REGS(3)) u_dut3 (
        .clock(clock), .reset(reset), .enable(enable3), .funSel(funSel), .i(i[15:0]),
        .rd_sel_a(rd_sel_a3), .rd_sel_b(rd_sel_b3),
        .o_a(o_a3), .o_b(o_b3), .zero_a(zero_a3), .wrap(wrap3)
    );

`ifdef REG_SATURATE_EN
    localparam logic [31:0] DEC0_VAL = 32'h0000_0000;
    localparam logic [31:0] INC1_VAL = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] DEC0_VAL = 32'hFFFF_FFFF;
    localparam logic [31:0] INC1_VAL = 32'h0000_0000;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic read_pair(input logic [1:0] a, input logic [1:0] b);
        rd_sel_a = a;
        rd_sel_b = b;
        #1;
    endtask

    initial begin
        reset = 1'b1; enable = 4'h0; funSel = 3'b000; i = 32'h0;
        rd_sel_a = 2'd0; rd_sel_b = 2'd3;
        enable3 = 3'b000; rd_sel_a3 = 2'd3; rd_sel_b3 = 2'd2;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check_val("rst_o_a", o_a, 32'h0);
        check_val("rst_zero_a", {31'd0, zero_a}, 32'd1);
        check_val("rst_wrap", {31'd0, wrap}, 32'd0);

        // Test 1: count all regs up, then async reset mid-cycle.
        @(negedge clock);
        enable = 4'hF; funSel = 3'b001;
        repeat (3) step();
        read_pair(2'd0, 2'd3);
        check_val("inc3_r0", o_a, 32'd3);
        check_val("inc3_r3", o_b, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_o_a", o_a, 32'h0);
        check_val("async_rst_o_b", o_b, 32'h0);
        check_val("async_rst_zero", {31'd0, zero_a}, 32'd1);
        check_val("async_rst_wrap", {31'd0, wrap}, 32'd0);
        @(negedge clock);
        enable = 4'h0;
        reset = 1'b0;

        // Test 2: decrement R0 from zero.
        enable = 4'b0001; funSel = 3'b000;
        step();
        read_pair(2'd0, 2'd1);
        check_val("dec0_r0", o_a, DEC0_VAL);
        check_val("dec0_wrap", {31'd0, wrap}, 32'd1);
        check_val("dec0_r1_hold", o_b, 32'h0);
        enable = 4'h0;
        step();
        check_val("idle_wrap", {31'd0, wrap}, 32'd0);
        check_val("idle_r0_hold", o_a, DEC0_VAL);

        // Test 3: load R1,R2; same-cycle read shows old value.
        read_pair(2'd1, 2'd2);
        enable = 4'b0110; funSel = 3'b010; i = 32'h1234_0000;
        #1;
        check_val("no_bypass_r1", o_a, 32'h0);
        step();
        check_val("load_r1", o_a, 32'h1234_0000);
        check_val("load_r2", o_b, 32'h1234_0000);
        check_val("load_wrap", {31'd0, wrap}, 32'd0);
        read_pair(2'd0, 2'd3);
        check_val("load_r0_hold", o_a, DEC0_VAL);
        check_val("load_r3_hold", o_b, 32'h0);

        // Test 4: byte shift-in on R2.
        enable = 4'b0100; funSel = 3'b110; i = 32'h0000_00AB;
        step();
        read_pair(2'd2, 2'd1);
        check_val("shift_r2", o_a, 32'h3400_00AB);
        check_val("shift_r1_hold", o_b, 32'h1234_0000);

        // Test 5: sign extend, zero extend 16, zero extend 8, clear on R3.
        read_pair(2'd3, 2'd0);
        enable = 4'b1000; funSel = 3'b111; i = 32'h0000_800F;
        step();
        check_val("sext_r3", o_a, 32'hFFFF_800F);
        funSel = 3'b101; i = 32'hFFFF_1234;
        step();
        check_val("zext16_r3", o_a, 32'h0000_1234);
        funSel = 3'b100; i = 32'hFFFF_FFAB;
        step();
        check_val("zext8_r3", o_a, 32'h0000_00AB);
        funSel = 3'b011;
        step();
        check_val("clr_r3", o_a, 32'h0);
        check_val("clr_zero_a", {31'd0, zero_a}, 32'd1);

        // Test 6: R1=all-ones, R0=5, increment both.
        enable = 4'b0010; funSel = 3'b010; i = 32'hFFFF_FFFF;
        step();
        enable = 4'b0001; i = 32'd5;
        step();
        enable = 4'b0011; funSel = 3'b001;
        step();
        read_pair(2'd0, 2'd1);
        check_val("inc_r0", o_a, 32'd6);
        check_val("inc_r1", o_b, INC1_VAL);
        check_val("inc_wrap", {31'd0, wrap}, 32'd1);
        enable = 4'b0001;
        step();
        check_val("inc_r0_nowrap", o_a, 32'd7);
        check_val("inc_nowrap", {31'd0, wrap}, 32'd0);
        funSel = 3'b000;
        step();
        check_val("dec_r0", o_a, 32'd6);
        check_val("dec_nowrap", {31'd0, wrap}, 32'd0);
        enable = 4'h0;

        // Non-power-of-two instance: index 3 reads zero.
        enable3 = 3'b111; funSel = 3'b010; i = 32'h0000_BEEF;
        step();
        enable3 = 3'b000;
        #1;
        check_val("oor_o_a3", {16'd0, o_a3}, 32'h0);
        check_val("oor_zero_a3", {31'd0, zero_a3}, 32'd1);
        check_val("r2_o_b3", {16'd0, o_b3}, 32'h0000_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
